// File: rtl/timer_cmd_serializer_if.sv
// Command-side bus of the timer-command serializer: request/capture
// signals in, status and the serial line out.
interface timer_cmd_serializer_if #(
    parameter int DATA_W = 4
);
    logic              start;
    logic [DATA_W-1:0] delay;
    logic              ack;
    logic              ready;
    logic              busy;
    logic              data;
    logic              done;

    // The command side (and the receiver's ack) drive the serializer
    modport master (
        output start, delay, ack,
        input  ready, busy, data, done
    );

    // The serializer itself
    modport slave (
        input  start, delay, ack,
        output ready, busy, data, done
    );
endinterface

// File: rtl/timer_cmd_serializer.sv
// Transmit end of the serial timer-command link. A captured delay value
// is sent as a 4-bit start pattern (bit 3 first) followed by the delay
// bits MSB first. The line then idles until the receiver acknowledges.
module timer_cmd_serializer #(
    parameter logic [3:0] PATTERN    = 4'b1101,
    parameter int         DATA_W     = 4,
    parameter logic       IDLE_LEVEL = 1'b0
) (
    input logic                   clk,
    input logic                   reset,
    timer_cmd_serializer_if.slave bus
);
    // The counter indexes both the 4 header bits and the delay bits.
    // It never wraps because every phase ends when it reaches zero.
    localparam int CNT_MAX = (DATA_W - 1 > 3) ? DATA_W - 1 : 3;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HDR_LAST_CNT  = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        WAIT_ACK
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  cnt_dec;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              data_q;
    logic              data_next;
    logic              done_q;
    logic              done_next;

    assign cnt_dec = cnt - CNT_ONE;

    // The line value is computed for the state being entered, so the
    // registered output lines up with that state: during HDR the line
    // carries PATTERN[cnt], and during DATA it carries the bit that was
    // the shift-register MSB when the state was entered.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        data_next  = IDLE_LEVEL;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = HDR;
                    cnt_next   = HDR_LAST_CNT;
                    shreg_next = bus.delay;
                    data_next  = PATTERN[3];
                end
            end
            HDR: begin
                if (cnt == '0) begin
                    state_next = DATA;
                    cnt_next   = DATA_LAST_CNT;
                    data_next  = shreg[DATA_W-1];
                    shreg_next = shreg << 1;
                end else begin
                    cnt_next  = cnt_dec;
                    data_next = PATTERN[cnt_dec[1:0]];
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    state_next = WAIT_ACK;
                end else begin
                    cnt_next   = cnt_dec;
                    data_next  = shreg[DATA_W-1];
                    shreg_next = shreg << 1;
                end
            end
            WAIT_ACK: begin
                if (bus.ack) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter, shift register and the registered outputs; reset
    // aborts any frame in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            data_q <= IDLE_LEVEL;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            shreg  <= shreg_next;
            data_q <= data_next;
            done_q <= done_next;
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state != IDLE);
    assign bus.data  = data_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_timer_cmd_serializer.sv
// Self-checking bench for timer_cmd_serializer. Expected line contents
// come from a frame model: the header pattern bits followed by the
// delay bits, MSB first.
module tb_timer_cmd_serializer;
    localparam int         DATA_W  = 4;
    localparam logic [3:0] PATTERN = 4'b1101;
    localparam int         FRAME_N = 4 + DATA_W;

    logic clk = 1'b0;
    logic reset;

    timer_cmd_serializer_if #(.DATA_W(DATA_W)) bus ();

    timer_cmd_serializer #(
        .PATTERN   (PATTERN),
        .DATA_W    (DATA_W),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    logic exp_bits[$];

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: header bit 3 down to 0, then delay MSB down to LSB
    function automatic void build_frame(input logic [DATA_W-1:0] d);
        logic [3:0] pat;
        pat = PATTERN;
        exp_bits = {};
        for (int i = 3; i >= 0; i--) exp_bits.push_back(pat[i]);
        for (int i = DATA_W - 1; i >= 0; i--) exp_bits.push_back(d[i]);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.delay = 4'b1010;
        tick();
        bus.start = 1'b0;
        tick();
        compared++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.data !== 1'b0 || bus.done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: ready=%b busy=%b data=%b done=%b, expected 1 0 0 0",
                     bus.ready, bus.busy, bus.data, bus.done);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++;
            if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.data !== 1'b0 || bus.done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_idle%0d: ready=%b busy=%b data=%b done=%b, expected 1 0 0 0",
                         c, bus.ready, bus.busy, bus.data, bus.done);
            end
        end
    endtask

    task automatic test_basic_frame();
        bus.delay = 4'b1011;
        bus.start = 1'b1;
        build_frame(4'b1011);
        tick();
        bus.start = 1'b0;
        bus.delay = 4'b0100;
        for (int i = 0; i < FRAME_N; i++) begin
            compared++;
            if (bus.data !== exp_bits[i] || bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL basic_bit%0d: data=%b busy=%b ready=%b, expected data=%b busy=1 ready=0",
                         i, bus.data, bus.busy, bus.ready, exp_bits[i]);
            end
            tick();
        end
        for (int w = 0; w < 20; w++) begin
            compared++;
            if (bus.data !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL basic_wait%0d: data=%b busy=%b done=%b, expected 0 1 0",
                         w, bus.data, bus.busy, bus.done);
            end
            tick();
        end
    endtask

    task automatic test_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        compared++;
        if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.data !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ack_done: done=%b ready=%b busy=%b data=%b, expected 1 1 0 0",
                     bus.done, bus.ready, bus.busy, bus.data);
        end
        tick();
        compared++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ack_pulse_width: done=%b ready=%b, expected 0 1", bus.done, bus.ready);
        end
    endtask

    task automatic test_start_held();
        bus.delay = 4'b0000;
        bus.start = 1'b1;
        build_frame(4'b0000);
        for (int c = 0; c < 12; c++) begin
            bus.ack = (c == 2);
            tick();
            compared++;
            if (c < FRAME_N) begin
                if (bus.data !== exp_bits[c] || bus.busy !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL held_bit%0d: data=%b busy=%b, expected data=%b busy=1",
                             c, bus.data, bus.busy, exp_bits[c]);
                end
            end else begin
                if (bus.data !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL held_wait%0d: data=%b busy=%b done=%b, expected 0 1 0",
                             c, bus.data, bus.busy, bus.done);
                end
            end
        end
        bus.start = 1'b0;
        bus.ack = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            compared++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL held_stay%0d: busy=%b done=%b, expected 1 0", w, bus.busy, bus.done);
            end
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        compared++;
        if (bus.done !== 1'b1 || bus.ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL held_close: done=%b ready=%b, expected 1 1", bus.done, bus.ready);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_W-1:0] d;
        bus.delay = 4'b1111;
        bus.start = 1'b1;
        build_frame(4'b1111);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (bus.data !== exp_bits[i]) begin
                mismatched++;
                $display("[TB] FAIL abort_bit%0d: data=%b, expected %b", i, bus.data, exp_bits[i]);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++;
        if (bus.data !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_idle: data=%b ready=%b busy=%b done=%b, expected 0 1 0 0",
                     bus.data, bus.ready, bus.busy, bus.done);
        end
        tick();
        compared++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL abort_no_done: done=%b ready=%b, expected 0 1", bus.done, bus.ready);
        end
        d = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        bus.delay = d;
        bus.start = 1'b1;
        build_frame(d);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < FRAME_N; i++) begin
            compared++;
            if (bus.data !== exp_bits[i] || bus.busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL after_abort_bit%0d: data=%b busy=%b, expected data=%b busy=1",
                         i, bus.data, bus.busy, exp_bits[i]);
            end
            tick();
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        compared++;
        if (bus.done !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL after_abort_done: done=%b, expected 1", bus.done);
        end
        tick();
    endtask

    task automatic test_ack_start_collision();
        bus.delay = 4'b0110;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < FRAME_N; i++) tick();
        build_frame(4'b0110);
        bus.ack = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.ack = 1'b0;
        compared++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b1 || bus.data !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL collide_idle: ready=%b done=%b data=%b, expected 1 1 0",
                     bus.ready, bus.done, bus.data);
        end
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < FRAME_N; i++) begin
            compared++;
            if (bus.data !== exp_bits[i] || bus.busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL collide_bit%0d: data=%b busy=%b, expected data=%b busy=1",
                         i, bus.data, bus.busy, exp_bits[i]);
            end
            tick();
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
    endtask

    task automatic test_random_frames();
        logic [DATA_W-1:0] d;
        int idle_n;
        int wait_n;
        for (int f = 0; f < 30; f++) begin
            idle_n = $urandom_range(0, 2);
            for (int c = 0; c < idle_n; c++) begin
                compared++;
                if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.data !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rand%0d_idle: ready=%b busy=%b data=%b, expected 1 0 0",
                             f, bus.ready, bus.busy, bus.data);
                end
                tick();
            end
            d = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            bus.delay = d;
            bus.start = 1'b1;
            build_frame(d);
            tick();
            for (int i = 0; i < FRAME_N; i++) begin
                compared++;
                if (bus.data !== exp_bits[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rand%0d_bit%0d: data=%b busy=%b done=%b, expected data=%b busy=1 done=0",
                             f, i, bus.data, bus.busy, bus.done, exp_bits[i]);
                end
                bus.start = 1'($urandom_range(0, 1));
                bus.ack   = 1'($urandom_range(0, 1));
                bus.delay = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
                tick();
            end
            bus.ack = 1'b0;
            wait_n = $urandom_range(0, 5);
            for (int w = 0; w < wait_n; w++) begin
                compared++;
                if (bus.data !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rand%0d_wait%0d: data=%b busy=%b done=%b, expected 0 1 0",
                             f, w, bus.data, bus.busy, bus.done);
                end
                bus.start = 1'($urandom_range(0, 1));
                tick();
            end
            bus.start = 1'b0;
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
            compared++;
            if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.data !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rand%0d_done: done=%b ready=%b data=%b, expected 1 1 0",
                         f, bus.done, bus.ready, bus.data);
            end
            tick();
        end
    endtask

    // Scenario sequence
    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ack = 1'b0;
        bus.delay = '0;
        test_reset();
        test_basic_frame();
        test_ack();
        test_start_held();
        test_reset_mid_frame();
        test_ack_start_collision();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/timer_cmd_serializer.md
Name: timer_cmd_serializer

Overview:
- Transmit end of the serial timer-command link.
- Takes a parallel delay value and sends a start pattern (default 1101) followed by the delay bits, MSB first, on a 1-bit serial line. The line feeds the downstream pattern-detect / shift-enable timer FSM.
- After sending, holds the line idle until the receiver's `ack` (its "done acknowledged" strobe) closes the transaction.
- Sits between the command/register side and the timer receive FSM.

Parameters:
- `PATTERN`, `4'b1101`: start-of-command header, sent bit 3 first.
- `DATA_W`, `4`: width of the delay field. Legal range is 1..8.
- `IDLE_LEVEL`, `1'b0`: value driven on `data` when no header or delay bit is being sent.

Ports:
- `clk`  input  1: clock, rising-edge.
- `reset`  input  1: synchronous, active-high. Restores the idle state.
- `start`  input  1: command request. Accepted only when `ready`=1.
- `delay`  input  `DATA_W`: delay value. Captured on the accepting edge.
- `ack`  input  1: receiver acknowledge. Honoured only in WAIT_ACK.
- `ready`  output  1: block idle and able to accept `start`.
- `busy`  output  1: transaction in progress (HDR, DATA, or WAIT_ACK).
- `data`  output  1: serial output line. Registered.
- `done`  output  1: one-cycle pulse when a transaction completes.

Behaviour:
- Reset and clock: reset is synchronous and active-high; the clock is `clk`. Reset wins over every other input on the same edge.
- Values after reset: state=IDLE, `data`=`IDLE_LEVEL`, `ready`=1, `busy`=0, `done`=0, bit counter=0, shift register=0.
- Decoded outputs: `ready` = (state==IDLE). `busy` = !`ready`. Both decode from state only; neither depends combinationally on inputs.
- `data` and `done` are registered outputs.
- FSM states: IDLE, HDR, DATA, WAIT_ACK.
  - IDLE: if `start`=1 at an edge, capture `delay` into the shift register, set bit counter=3, go to HDR. Otherwise stay.
  - HDR: `data`=`PATTERN`[cnt]. Counter decrements each cycle. After cnt=0 is driven, go to DATA with cnt=`DATA_W`-1. Lasts exactly 4 cycles.
  - DATA: `data` = shift register MSB. Shift left by one each cycle. After the last bit, go to WAIT_ACK. Lasts exactly `DATA_W` cycles.
  - WAIT_ACK: `data`=`IDLE_LEVEL`. If `ack`=1 at an edge, go to IDLE and pulse `done`=1 for the following cycle. No timeout: the block waits indefinitely.
- Latency: `start` accepted at edge k gives the following schedule.
  - Header bits appear on `data` in cycles k+1..k+4.
  - Delay bits appear in cycles k+5..k+4+`DATA_W`.
  - WAIT_ACK starts at cycle k+5+`DATA_W`.
- Ignored inputs:
  - `start` while `busy`=1 is ignored and not queued.
  - `ack` outside WAIT_ACK is ignored, including an `ack` pulse during HDR or DATA.
  - `delay` changes after the capture edge do not affect the frame in flight.
- Simultaneous `ack` and `start`: at the WAIT_ACK→IDLE edge, a coincident `start` is ignored because `ready`=0 at that edge. The earliest new accept is the next edge, so back-to-back frames are separated by at least one IDLE cycle.
- Reset mid-frame: the frame is aborted immediately. `data` returns to `IDLE_LEVEL` the next cycle, and no `done` pulse is generated.
- Width and wrap rules:
  - The bit counter is sized to hold max(3, `DATA_W`-1).
  - The counter never wraps, because state transitions occur at cnt=0.
  - The shift register is `DATA_W` bits and is zero-filled on shift.

Test Plan:
- Reset, then idle 5 cycles → `ready`=1, `busy`=0, `data`=0, `done`=0 throughout.
- `start`=1 with `delay`=4'b1011 for one cycle → `data` over the next 8 cycles is 1,1,0,1,1,0,1,1. Then `data`=0 and `busy`=1 hold for 20 cycles with `ack`=0.
- From WAIT_ACK, pulse `ack` for 1 cycle → next cycle `done`=1 (exactly 1 cycle), `ready`=1, `busy`=0.
- `delay`=4'b0000 frame, with `start` held high for 12 cycles and `ack` pulsed in cycle 3 → exactly one frame is sent (1,1,0,1,0,0,0,0), the early `ack` is ignored, and the block stays in WAIT_ACK.
- Assert `reset` in the 6th cycle of a `delay`=4'b1111 frame → the next cycle shows `data`=0 and `ready`=1 with no `done`. A new `start` then produces a full, correct frame.
- `ack` and `start` high on the same edge in WAIT_ACK (`delay`=4'b0110) → no frame starts. Holding `start` through the next cycle makes the header begin one cycle later, followed by 0,1,1,0.
